mul_div_controller: RTL

- Sequences the multiply/divide resource and owns the architectural HI/LO registers.
- Accepts one mult/multu/div/divu request at a time from the EX stage, which decodes the ID-to-EX multiply_valid, divide_valid and multiply_divide_signed fields.
- Runs a multi-cycle multiply or a radix-2 restoring divide and commits the result to HI/LO.
- Applies direct mthi/mtlo writes, exposes busy for pipeline stalls, and honours exception/eret flushes.

---
 rtl/mul_div_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mul_div_controller.sv
// Multi-cycle mul/div sequencer owning HI/LO: multiply commits MUL_LATENCY edges after accept, divide 33.
// One operation in flight; request_ready (state == IDLE) is the only backpressure, flush cancels work.
module mul_div_controller #(
  parameter int CPU_DATA_WIDTH = 32,
  parameter int MUL_LATENCY    = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      request_valid,
  output logic                      request_ready,
  input  logic                      request_is_divide,
  input  logic                      request_signed,
  input  logic [CPU_DATA_WIDTH-1:0] source1,
  input  logic [CPU_DATA_WIDTH-1:0] source2,
  input  logic                      flush,
  input  logic                      hi_lo_write_valid,
  input  logic                      write_high,
  input  logic [CPU_DATA_WIDTH-1:0] write_value,
  output logic                      busy,
  output logic                      done,
  output logic [CPU_DATA_WIDTH-1:0] high_value,
  output logic [CPU_DATA_WIDTH-1:0] low_value
);

  localparam int W   = CPU_DATA_WIDTH;
  localparam int DCW = $clog2(W + 1);
  localparam int MCW = $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_nxt;
  logic             accept, commit;
  logic [W-1:0]     op_a, op_b, rem_q, hi_q, lo_q;
  logic             is_signed, neg_quo, neg_rem, done_q;
  logic [MCW-1:0]   mul_cnt;
  logic [DCW-1:0]   div_cnt;

  logic [2*W-1:0]   ext_a, ext_b, product;
  logic [W:0]       rem_shift, trial;
  logic             quo_bit;
  logic [W-1:0]     rem_next, abs_a, abs_b, commit_hi, commit_lo;

  assign request_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign done          = done_q;
  assign high_value    = hi_q;
  assign low_value     = lo_q;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (request_valid && !flush) begin
          accept    = 1'b1;
          state_nxt = request_is_divide ? DIV : MUL;
        end
      end
      MUL: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (mul_cnt == MCW'(MUL_LATENCY)) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      DIV: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (div_cnt == DCW'(W)) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Low half of a 2W x 2W product of extended operands is the exact signed/unsigned result.
  always_comb begin
    ext_a   = is_signed ? {{W{op_a[W-1]}}, op_a} : {{W{1'b0}}, op_a};
    ext_b   = is_signed ? {{W{op_b[W-1]}}, op_b} : {{W{1'b0}}, op_b};
    product = ext_a * ext_b;
  end

  // Restoring step: op_a shifts dividend bits out MSB-first and quotient bits in.
  always_comb begin
    rem_shift = {rem_q, op_a[W-1]};
    trial     = rem_shift - {1'b0, op_b};
    quo_bit   = !trial[W];
    rem_next  = quo_bit ? trial[W-1:0] : rem_shift[W-1:0];
    abs_a     = (request_signed && source1[W-1]) ? -source1 : source1;
    abs_b     = (request_signed && source2[W-1]) ? -source2 : source2;
  end

  always_comb begin
    commit_hi = product[2*W-1:W];
    commit_lo = product[W-1:0];
    if (state == DIV) begin
      commit_hi = neg_rem ? -rem_q : rem_q;
      commit_lo = neg_quo ? -op_a  : op_a;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      op_a      <= '0;
      op_b      <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_signed <= 1'b0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      done_q    <= 1'b0;
      mul_cnt   <= '0;
      div_cnt   <= '0;
    end else begin
      done_q <= commit;
      if (accept) begin
        is_signed <= request_signed;
        mul_cnt   <= MCW'(1);
        div_cnt   <= '0;
        rem_q     <= '0;
        neg_quo   <= request_signed && (source1[W-1] ^ source2[W-1]);
        neg_rem   <= request_signed && source1[W-1];
        op_a      <= request_is_divide ? abs_a : source1;
        op_b      <= request_is_divide ? abs_b : source2;
      end else if (state == MUL && mul_cnt != MCW'(MUL_LATENCY)) begin
        mul_cnt <= mul_cnt + MCW'(1);
      end else if (state == DIV && div_cnt != DCW'(W)) begin
        op_a    <= {op_a[W-2:0], quo_bit};
        rem_q   <= rem_next;
        div_cnt <= div_cnt + DCW'(1);
      end
      if (commit) begin
        hi_q <= commit_hi;
        lo_q <= commit_lo;
      end
      // Direct mthi/mtlo overrides a same-edge commit for its own target only.
      if (hi_lo_write_valid) begin
        if (write_high) hi_q <= write_value;
        else            lo_q <= write_value;
      end
    end
  end

endmodule
